// File: rtl/sum_group_accumulator.sv
// sum_group_accumulator
//   Sums `group` consecutive unsigned elements from the up stream and presents
//   the total on the down stream. Two states: ACCUM collects elements, and HOLD
//   presents the result until the consumer takes it. A flush closes a partial
//   group early. There is one bubble per group, because up_ready is a pure
//   function of state.
//
// Parameters
//   width      element width (up_data)
//   group      elements per output word, 2..255
//   acc_width  accumulator / down_data width, >= width
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   up_valid    element on up_data is valid
//   up_ready    block accepts an element (high in ACCUM)
//   up_data     unsigned element
//   flush       close the current partial group (ignored when empty or in HOLD)
//   down_valid  group result valid (high in HOLD)
//   down_ready  consumer accepts the result
//   down_data   group total
//   down_count  elements in down_data (1..group)
//   down_sat    total clamped (saturating build only, else 0)
//
// Configuration
//   SUM_GROUP_ACCUMULATOR_SATURATE_EN  defined: clamp on overflow and flag
//                                      down_sat; undefined: wrap modulo
//                                      2^acc_width.

module sum_group_accumulator #(
   parameter int unsigned width     = 8,
   parameter int unsigned group     = 4,
   parameter int unsigned acc_width = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 up_valid,
   output logic                 up_ready,
   input  logic [width-1:0]     up_data,
   input  logic                 flush,
   output logic                 down_valid,
   input  logic                 down_ready,
   output logic [acc_width-1:0] down_data,
   output logic [7:0]           down_count,
   output logic                 down_sat
);

   localparam logic [7:0] GroupCnt = 8'(group);

   typedef enum logic [0:0] {StAccum, StHold} state_e;

   state_e               state_q, state_d;
   logic [acc_width-1:0] acc_q, acc_d;
   logic [7:0]           cnt_q, cnt_d;
   logic                 close_group;

`ifdef SUM_GROUP_ACCUMULATOR_SATURATE_EN
   logic                 sat_q, sat_d;
   // One extra bit catches the carry out of the accumulator.
   logic [acc_width:0]   sum;
   assign sum = {1'b0, acc_q} + (acc_width + 1)'(up_data);
`endif

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      close_group = 1'b0;
`ifdef SUM_GROUP_ACCUMULATOR_SATURATE_EN
      sat_d       = sat_q;
`endif
      unique case (state_q)
         StAccum: begin
            if (up_valid) begin
               cnt_d = cnt_q + 8'd1;
`ifdef SUM_GROUP_ACCUMULATOR_SATURATE_EN
               if (sum[acc_width]) begin
                  acc_d = '1;
                  sat_d = 1'b1;
               end else begin
                  acc_d = sum[acc_width-1:0];
               end
`else
               acc_d = acc_q + acc_width'(up_data);
`endif
               // A flush alongside an element closes the group with that element in it.
               close_group = (cnt_d == GroupCnt) || flush;
            end else begin
               // An empty group never produces a result.
               close_group = flush && (cnt_q != 8'd0);
            end
            if (close_group) state_d = StHold;
         end
         StHold: begin
            if (down_ready) begin
               state_d = StAccum;
               acc_d   = '0;
               cnt_d   = '0;
`ifdef SUM_GROUP_ACCUMULATOR_SATURATE_EN
               sat_d   = 1'b0;
`endif
            end
         end
         default: state_d = StAccum;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StAccum;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef SUM_GROUP_ACCUMULATOR_SATURATE_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sat_q <= 1'b0;
      else      sat_q <= sat_d;
   end
   assign down_sat = sat_q;
`else
   assign down_sat = 1'b0;
`endif

   // Outputs come straight from state, so they hold still throughout HOLD.
   assign up_ready   = (state_q == StAccum);
   assign down_valid = (state_q == StHold);
   assign down_data  = acc_q;
   assign down_count = cnt_q;

endmodule
